prm_edge_scan_seq: RTL and testbench

Query-side sequencer for the PRM obstacle-check lookups. It sweeps a contiguous range of 15-bit edge/configuration codes into a combinational `prm_oblgc_chk*` checker, one code per cycle, and samples the returned `edge_mask` bit. It packs the results into PACK-bit words on a valid/ready stream and keeps a count of blocked edges. It sits between the roadmap builder (range requests) and the edge-mask store (packed words).

---
 rtl/prm_edge_scan_seq.sv | 141 ++++++++++++++
 tb/tb_prm_edge_scan_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prm_edge_scan_seq.sv
// Query-side sequencer for PRM obstacle-check lookups: sweeps a code range into the
// combinational checker one code per cycle and packs the returned mask bits into words.
module prm_edge_scan_seq #(
   parameter int QW   = 15,
   parameter int PACK = 16,
   parameter int CW   = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [QW-1:0]   base_code,
   input  logic [CW-1:0]   count,
   output logic [QW-1:0]   query,
   output logic            query_vld,
   input  logic            edge_mask_in,
   output logic [PACK-1:0] m_data,
   output logic            m_last,
   output logic            m_valid,
   input  logic            m_ready,
   output logic            busy,
   output logic            done,
   output logic [CW-1:0]   blocked_cnt,
   output logic [1:0]      dbg_state
);

   localparam int IW = (PACK > 1) ? $clog2(PACK) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, FLUSH, FIN} state_t;

   // Stream handshake: a word transfers on a rising edge where m_valid && m_ready;
   // m_data/m_last/m_valid hold steady while m_valid && !m_ready.
   state_t          state;
   logic [CW-1:0]   rem;
   logic [PACK-1:0] pack;
   logic [IW-1:0]   idx;
   logic            pend;
   logic            pend_last;

   logic            acc;
   logic            out_free;
   logic            is_last;
   logic            word_done;
   logic [PACK-1:0] new_pack;

   assign acc       = m_valid & m_ready;
   assign out_free  = ~m_valid | acc;
   assign is_last   = (rem == CW'(1));
   assign word_done = (idx == IW'(PACK - 1)) | is_last;
   assign new_pack  = pack | (PACK'(edge_mask_in) << idx);
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         query       <= '0;
         query_vld   <= 1'b0;
         rem         <= '0;
         pack        <= '0;
         idx         <= '0;
         pend        <= 1'b0;
         pend_last   <= 1'b0;
         m_data      <= '0;
         m_last      <= 1'b0;
         m_valid     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         blocked_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  query       <= base_code;
                  rem         <= count;
                  pack        <= '0;
                  idx         <= '0;
                  pend        <= 1'b0;
                  blocked_cnt <= '0;
                  busy        <= 1'b1;
                  if (count != '0) begin
                     state     <= SCAN;
                     query_vld <= 1'b1;
                  end else begin
                     state <= FIN;
                     done  <= 1'b1;
                  end
               end
            end
            SCAN, FLUSH: begin
               if (query_vld) begin
                  query <= query + QW'(1);
                  rem   <= rem - CW'(1);
                  idx   <= word_done ? '0 : idx + IW'(1);
                  if (edge_mask_in && (blocked_cnt != {CW{1'b1}}))
                     blocked_cnt <= blocked_cnt + CW'(1);
                  if (word_done) begin
                     if (out_free) begin
                        m_data  <= new_pack;
                        m_last  <= is_last;
                        m_valid <= 1'b1;
                        pack    <= '0;
                     end else begin
                        // Output register still busy: park the word and freeze the sweep.
                        pack      <= new_pack;
                        pend      <= 1'b1;
                        pend_last <= is_last;
                        query_vld <= 1'b0;
                     end
                  end else begin
                     pack <= new_pack;
                     if (acc) m_valid <= 1'b0;
                  end
                  if (is_last) begin
                     query_vld <= 1'b0;
                     state     <= FLUSH;
                  end
               end else if (pend && out_free) begin
                  m_data  <= pack;
                  m_last  <= pend_last;
                  m_valid <= 1'b1;
                  pack    <= '0;
                  pend    <= 1'b0;
                  if (state == SCAN) query_vld <= 1'b1;
               end else begin
                  if (acc) m_valid <= 1'b0;
                  if ((state == FLUSH) && acc && m_last) begin
                     state <= FIN;
                     done  <= 1'b1;
                  end
               end
            end
            FIN: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prm_edge_scan_seq.sv
// Randomized scoreboard bench for prm_edge_scan_seq: a sweep model fills the expected
// word queue at start; a negedge monitor pops and compares on every stream transfer.
module tb_prm_edge_scan_seq;
   localparam int QW = 15, PACK = 16, CW = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [QW-1:0]   base_code = '0;
   logic [CW-1:0]   count = '0;
   logic [QW-1:0]   query;
   logic            query_vld;
   logic            edge_mask_in;
   logic [PACK-1:0] m_data;
   logic            m_last;
   logic            m_valid;
   logic            m_ready = 1'b1;
   logic            busy;
   logic            done;
   logic [CW-1:0]   blocked_cnt;
   logic [1:0]      dbg_state;

   prm_edge_scan_seq #(.QW(QW), .PACK(PACK), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_code(base_code), .count(count),
      .query(query), .query_vld(query_vld), .edge_mask_in(edge_mask_in),
      .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
      .busy(busy), .done(done), .blocked_cnt(blocked_cnt), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset / checker model ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;

   int          mode = 0;        // 0: mask = code[0], 1: all blocked, 2: parity of code & key
   logic [QW-1:0] key = '0;

   function automatic logic chk(input logic [QW-1:0] q);
      case (mode)
         0:       return q[0];
         1:       return 1'b1;
         default: return ^(q & key);
      endcase
   endfunction

   always_comb begin
      case (mode)
         0:       edge_mask_in = query[0];
         1:       edge_mask_in = 1'b1;
         default: edge_mask_in = ^(query & key);
      endcase
   end

   // ---------------- scoreboard ----------------
   logic [PACK:0]   exp_q[$];    // {last, data}
   logic [QW-1:0]   exp_code;
   int              q_left = 0;
   int              exp_blocked = 0;
   logic [PACK:0]   last_word = '0;
   int              tests = 0;
   int              fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_sweep(input logic [QW-1:0] base, input int cnt);
      logic [PACK-1:0] w;
      logic [QW-1:0]   code;
      logic            b;
      int              pos;
      int              ones;
      w = '0; pos = 0; ones = 0;
      for (int k = 0; k < cnt; k++) begin
         code = QW'(int'(base) + k);
         b = chk(code);
         if (b) ones++;
         w[pos] = b;
         pos++;
         if (pos == PACK || k == cnt - 1) begin
            exp_q.push_back({(k == cnt - 1) ? 1'b1 : 1'b0, w});
            w = '0;
            pos = 0;
         end
      end
      exp_blocked = (ones > 65535) ? 65535 : ones;
      exp_code    = base;
      q_left      = cnt;
   endtask

   // ---------------- monitor ----------------
   logic          hold_pending = 1'b0;
   logic [PACK:0] held = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         hold_pending = 1'b0;
      end else begin
         if (hold_pending) begin
            check("hold_valid", m_valid, 1);
            check("hold_word", {m_last, m_data}, held);
         end
         hold_pending = m_valid && !m_ready;
         held = {m_last, m_data};
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL extra_word: got %0h expected none (cycle %0d)", {m_last, m_data}, cyc);
            end else begin
               last_word = {m_last, m_data};
               check("word", {m_last, m_data}, exp_q.pop_front());
            end
         end
         if (query_vld) begin
            if (q_left == 0) begin
               tests++; fails++;
               $display("FAIL extra_query: got %0h expected none (cycle %0d)", query, cyc);
            end else begin
               check("query", query, exp_code);
               exp_code = exp_code + QW'(1);
               q_left--;
            end
         end
      end
   end

   // ---------------- drivers ----------------
   logic rnd_ready = 1'b0;
   always @(posedge clk) if (rnd_ready) begin
      #1 m_ready = ($urandom_range(0, 3) != 0);
   end

   int t0 = 0;

   task automatic start_sweep(input logic [QW-1:0] base, input int cnt);
      @(posedge clk); #1;
      start = 1'b1; base_code = base; count = CW'(cnt);
      push_sweep(base, cnt);
      t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_t1", busy, 1);
      if (cnt != 0) begin
         check("qvld_t1", query_vld, 1);
         check("query_t1", query, base);
      end else begin
         check("qvld_t1_zero", query_vld, 0);
         check("done_t1", done, 1);
      end
   endtask

   task automatic wait_done(input int exp_lat, input int limit);
      int n;
      n = 0;
      while (done !== 1'b1 && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
      if (done !== 1'b1) begin
         tests++; fails++;
         $display("FAIL done_timeout: got no done expected done within %0d cycles", limit);
      end else begin
         if (exp_lat >= 0) check("done_lat", cyc - t0, exp_lat);
         check("blocked", blocked_cnt, exp_blocked);
         check("exp_q_empty", exp_q.size(), 0);
         check("queries_left", q_left, 0);
         @(posedge clk); #1;
         check("done_pulse", done, 0);
         check("busy_idle", busy, 0);
         repeat (2) @(posedge clk);
         #1 check("blocked_hold", blocked_cnt, exp_blocked);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_query"}, query, 0);
      check({tag, "_qvld"}, query_vld, 0);
      check({tag, "_mdata"}, m_data, 0);
      check({tag, "_mlast"}, m_last, 0);
      check({tag, "_mvalid"}, m_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_blocked"}, blocked_cnt, 0);
      check({tag, "_state"}, dbg_state, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [QW-1:0] b;
      int n;
      repeat (3) @(posedge clk);
      #1 check_reset_vals("reset");
      rst_n = 1'b1;

      // 16 codes from 0, mask = code[0]: one word 0xAAAA, 8 blocked, done at T+18
      mode = 0; m_ready = 1'b1;
      start_sweep(15'h0000, 16);
      wait_done(18, 100);
      check("word_aaaa", last_word, {1'b1, 16'hAAAA});

      // wrap-around sweep, all blocked
      mode = 1;
      start_sweep(15'h7FFE, 20);
      wait_done(22, 100);
      check("word_000f", last_word, {1'b1, 16'h000F});

      // empty sweep
      mode = 0;
      start_sweep($urandom_range(0, 32767), 0);
      wait_done(1, 10);

      // stall: hold m_ready low for 30 cycles after the first m_valid
      mode = 2; key = QW'($urandom);
      m_ready = 1'b0;
      b = QW'($urandom);
      start_sweep(b, 40);
      n = 0;
      while (m_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      check("stall_first_valid", m_valid, 1);
      repeat (30) @(posedge clk);
      #1;
      check("stall_qvld", query_vld, 0);
      check("stall_query", query, b + QW'(32));
      m_ready = 1'b1;
      wait_done(-1, 200);

      // randomized sweeps with random backpressure
      rnd_ready = 1'b1;
      for (int s = 0; s < 6; s++) begin
         mode = 2; key = QW'($urandom);
         start_sweep(QW'($urandom), $urandom_range(1, 70));
         wait_done(-1, 2000);
      end
      rnd_ready = 1'b0;
      @(posedge clk); #1 m_ready = 1'b1;

      // start while busy is ignored, then an asynchronous reset mid-sweep
      mode = 2; key = QW'($urandom);
      start_sweep(QW'($urandom), 100);
      repeat (10) @(posedge clk);
      #1 start = 1'b1; base_code = QW'($urandom); count = 16'd5;
      @(posedge clk); #1 start = 1'b0;
      repeat (14) @(posedge clk);
      check("busy_mid", busy, 1);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("async_rst");
      exp_q.delete(); q_left = 0;
      @(posedge clk); #1 rst_n = 1'b1;
      mode = 1;
      start_sweep(QW'($urandom), 33);
      wait_done(35, 100);
      check("post_rst_last", last_word, {1'b1, 16'h0001});

      // maximum count, all blocked
      mode = 1;
      start_sweep(QW'($urandom), 65535);
      wait_done(65537, 70000);
      check("max_last_word", last_word, {1'b1, 16'h7FFF});
      check("max_blocked", blocked_cnt, 16'hFFFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

endmodule
